// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity link (generator, receiver, bench model).
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package parity_pkg;

  localparam int ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } rx_state_e;

  // Parity bit the generator appends after a word. Words narrower than 32 bits
  // are zero-extended, which leaves the XOR reduction unchanged.
  function automatic logic exp_parity(input logic [31:0] word, input logic even);
    return (^word) ^ even;
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in parallel-out register; first bit shifted in ends up at the MSB.
// Latency: q reflects din one clk after a shift_en cycle.
// Backpressure: none; shifts whenever shift_en is high, clr has priority.
//
// Ports:
//   clk, rst     : clock and asynchronous active-high reset
//   shift_en     : shift din into the LSB, moving older bits toward the MSB
//   clr          : synchronous clear of the whole register
//   din          : serial input bit
//   q            : parallel contents
module sipo_shift_reg #(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_en,
  input  logic                clr,
  input  logic                din,
  output logic [NUM_BITS-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[NUM_BITS-2:0], din};
    end
  end

endmodule

// File: rtl/parity_check_rx.sv
// Serial receiver: deserialises NUM_BITS data bits plus a trailing parity bit.
// Latency: data_out/data_valid/parity_err one clk after the parity bit is sampled.
// Backpressure: none; consumer must take data_out on data_valid (it then holds).
//
// Ports:
//   clk, rst    : clock and asynchronous active-high reset
//   data_in     : serial bit, qualified by wr_en
//   wr_en       : high for NUM_BITS+1 consecutive cycles per frame
//   data_out    : last completed word, MSB = first bit received
//   data_valid  : one-cycle pulse per completed frame
//   parity_err  : one-cycle pulse with data_valid when parity mismatches
//   frame_err   : one-cycle pulse when wr_en drops mid-frame
//   err_cnt     : saturating count of parity plus framing errors
module parity_check_rx
  import parity_pkg::*;
#(
  parameter int   NUM_BITS        = 8,
  parameter logic EVEN_PARITY_BIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_in,
  input  logic                 wr_en,
  output logic [NUM_BITS-1:0]  data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int CNT_W = $clog2(NUM_BITS + 1);

  rx_state_e           state, state_nxt;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
  logic [NUM_BITS-1:0] shift_q;
  logic                shift_en, shift_clr;
  logic                vld_nxt, perr_nxt, ferr_nxt;

  sipo_shift_reg #(
    .NUM_BITS (NUM_BITS)
  ) u_sipo (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .clr      (shift_clr),
    .din      (data_in),
    .q        (shift_q)
  );

  // Leaving PARITY always goes through IDLE, so a wr_en still high on the
  // following cycle is naturally taken as bit one of the next frame.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_en    = 1'b0;
    shift_clr   = 1'b0;
    vld_nxt     = 1'b0;
    perr_nxt    = 1'b0;
    ferr_nxt    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (wr_en) begin
          shift_en    = 1'b1;
          bit_cnt_nxt = CNT_W'(1);
          state_nxt   = ST_DATA;
        end
      end

      ST_DATA: begin
        if (wr_en) begin
          shift_en    = 1'b1;
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
          if (bit_cnt + CNT_W'(1) == CNT_W'(NUM_BITS)) begin
            state_nxt = ST_PARITY;
          end
        end else begin
          ferr_nxt    = 1'b1;
          shift_clr   = 1'b1;
          bit_cnt_nxt = '0;
          state_nxt   = ST_IDLE;
        end
      end

      ST_PARITY: begin
        bit_cnt_nxt = '0;
        state_nxt   = ST_IDLE;
        if (wr_en) begin
          vld_nxt  = 1'b1;
          // A good frame XORs (word plus parity bit) to the convention bit.
          perr_nxt = (^{shift_q, data_in}) ^ EVEN_PARITY_BIT;
        end else begin
          ferr_nxt  = 1'b1;
          shift_clr = 1'b1;
        end
      end

      default: begin
        bit_cnt_nxt = '0;
        shift_clr   = 1'b1;
        state_nxt   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      data_valid <= vld_nxt;
      parity_err <= perr_nxt;
      frame_err  <= ferr_nxt;
      // Word is published even when parity fails; it holds until the next frame.
      if (vld_nxt) begin
        data_out <= shift_q;
      end
      // Parity and framing errors are mutually exclusive in a given cycle.
      if ((perr_nxt || ferr_nxt) && (err_cnt != {ERR_CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_parity_check_rx.sv
module tb_parity_check_rx;
  import parity_pkg::*;

  localparam int NB = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 data_in;
  logic                 wr_en;
  logic [NB-1:0]        data_out;
  logic                 data_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic [ERR_CNT_W-1:0] err_cnt;

  parity_check_rx #(
    .NUM_BITS        (NB),
    .EVEN_PARITY_BIT (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .wr_en      (wr_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] word;
    logic          perr;
    int            cyc;
  } exp_t;

  exp_t sb_q[$];
  int   fe_q[$];
  exp_t mon_e;
  int   mon_fe;
  int   n_chk   = 0;
  int   n_err   = 0;
  int   cyc     = 0;
  int   exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic void bump_cnt();
    if (exp_cnt < 255) exp_cnt++;
  endfunction

  // Monitor: cycle counter advances on each rising edge; outputs sampled 1 ns later.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rst === 1'b0) begin
      if (data_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_valid", data_valid, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check("data_out", data_out, mon_e.word);
          check("parity_err", parity_err, mon_e.perr);
          check("valid_cycle", cyc, mon_e.cyc);
        end
      end else if (parity_err !== 1'b0) begin
        check("parity_err_without_valid", parity_err, 0);
      end
      if (frame_err === 1'b1) begin
        if (fe_q.size() == 0) begin
          check("unexpected_frame_err", frame_err, 0);
        end else begin
          mon_fe = fe_q.pop_front();
          check("frame_err_cycle", cyc, mon_fe);
        end
      end
    end
  end

  // Inputs change on the falling edge; the following rising edge (cyc+1) samples them.
  task automatic drive(input logic we, input logic b);
    @(negedge clk);
    wr_en   = we;
    data_in = b;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [NB-1:0] w, input logic p);
    exp_t x;
    for (int i = NB - 1; i >= 0; i--) drive(1'b1, w[i]);
    drive(1'b1, p);
    x.word = w;
    x.perr = (p != exp_parity(32'(w), 1'b1));
    x.cyc  = cyc + 1;
    sb_q.push_back(x);
    if (x.perr) bump_cnt();
  endtask

  task automatic abort_after(input int nbits);
    for (int i = 0; i < nbits; i++) drive(1'b1, i[0]);
    drive(1'b0, 1'b0);
    fe_q.push_back(cyc + 1);
    bump_cnt();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    data_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_data_out", data_out, 0);
    check("rst_valid", data_valid, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst = 1'b0;
    idle(2);

    // Good frame
    send_frame(4'b1001, 1'b1);
    idle(3);
    check("good_err_cnt", err_cnt, exp_cnt);
    check("good_drained", sb_q.size(), 0);

    // Bad parity; word still published and then held
    send_frame(4'b1001, 1'b0);
    idle(3);
    check("badpar_err_cnt", err_cnt, exp_cnt);
    check("badpar_hold", data_out, 4'b1001);

    // Abort after two bits, then recover
    abort_after(2);
    idle(3);
    check("abort_err_cnt", err_cnt, exp_cnt);
    check("abort_fe_drained", fe_q.size(), 0);
    check("abort_no_valid", sb_q.size(), 0);
    send_frame(4'b0110, 1'b1);
    idle(3);
    check("recover_err_cnt", err_cnt, exp_cnt);

    // Abort during the parity slot
    abort_after(NB);
    idle(3);
    check("abort_par_err_cnt", err_cnt, exp_cnt);

    // Back-to-back frames, wr_en held for 10 cycles
    send_frame(4'b1001, 1'b1);
    send_frame(4'b1110, 1'b0);
    idle(3);
    check("b2b_err_cnt", err_cnt, exp_cnt);
    check("b2b_drained", sb_q.size(), 0);

    // Reset mid-frame
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    @(negedge clk);
    rst   = 1'b1;
    wr_en = 1'b0;
    #1;
    check("midrst_data_out", data_out, 0);
    check("midrst_valid", data_valid, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_err_cnt", err_cnt, 0);
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    send_frame(4'b1010, 1'b1);
    idle(3);
    check("postrst_err_cnt", err_cnt, exp_cnt);
    check("postrst_data_out", data_out, 4'b1010);

    // Saturation: 300 bad-parity frames back-to-back
    repeat (300) send_frame(4'b0011, 1'b0);
    idle(3);
    check("sat_err_cnt", err_cnt, 8'hFF);
    check("sat_model", err_cnt, exp_cnt);

    check("final_sb_empty", sb_q.size(), 0);
    check("final_fe_empty", fe_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
